sysx_master_v2: RTL and testbench

//  sysX version 2 bus master: parametrised successor to the v1 controller.

---
 rtl/sysx_v2_pkg.sv | 34 +++
 rtl/sysx_master_v2_if.sv | 13 +
 rtl/sysx_v2_buffer.sv | 27 ++
 rtl/sysx_master_v2.sv | 217 +++++++++++++++++++++
 tb/tb_sysx_master_v2.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sysx_v2_pkg.sv
// sysX v2 master: shared types and constants (FSM states, register map,
// CTRL/STATUS bit positions, the unmapped-register read value).
package sysx_v2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_STORE,
        ST_DONE
    } state_t;

    localparam logic [2:0] REG_CTRL      = 3'd0;
    localparam logic [2:0] REG_CLKDIV    = 3'd1;
    localparam logic [2:0] REG_STATUS    = 3'd2;
    localparam logic [2:0] REG_MOSI_PTR  = 3'd3;
    localparam logic [2:0] REG_MOSI_DATA = 3'd4;
    localparam logic [2:0] REG_MISO_PTR  = 3'd5;
    localparam logic [2:0] REG_MISO_DATA = 3'd6;
    localparam logic [2:0] REG_BAD       = 3'd7;

    localparam int CTRL_GO  = 0;
    localparam int CTRL_IE  = 1;
    localparam int CTRL_SEL = 2;
    localparam int CTRL_LEN = 16;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_ERR  = 2;
    localparam int STAT_BIRQ = 3;

    localparam logic [31:0] BADC0DE = 32'h0BADC0DE;

endpackage

// File: rtl/sysx_master_v2_if.sv
// sysX v2 master: CPU register-bus interface. The CPU drives through the
// master modport; the sysX master block sits on the slave modport.
interface sysx_master_v2_if;
    logic [2:0]  iAddress;
    logic [31:0] iData;
    logic [31:0] oData;
    logic        iWrite;
    logic        iRead;
    logic        oInterrupt;

    modport master (output iAddress, iData, iWrite, iRead, input oData, oInterrupt);
    modport slave  (input iAddress, iData, iWrite, iRead, output oData, oInterrupt);
endinterface

// File: rtl/sysx_v2_buffer.sv
// sysX v2 master: single-clock true-dual-port DEPTHx32 word buffer.
// Synchronous read on both ports; a read colliding with a write to the
// same address returns the word held before the write.
module sysx_v2_buffer #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          a_we_i,
    input  logic [AW-1:0] a_addr_i,
    input  logic [31:0]   a_wdata_i,
    output logic [31:0]   a_rdata_o,
    input  logic          b_we_i,
    input  logic [AW-1:0] b_addr_i,
    input  logic [31:0]   b_wdata_i,
    output logic [31:0]   b_rdata_o
);
    logic [31:0] mem_q [DEPTH];

    // Both ports share one process so the array has a single driver; reads see pre-write contents.
    always_ff @(posedge clk_i) begin
        if (a_we_i) mem_q[a_addr_i] <= a_wdata_i;
        if (b_we_i) mem_q[b_addr_i] <= b_wdata_i;
        a_rdata_o <= mem_q[a_addr_i];
        b_rdata_o <= mem_q[b_addr_i];
    end
endmodule

// File: rtl/sysx_master_v2.sv
// sysX v2 bus master: moves blocks of 32-bit words between the MOSI/MISO
// buffers and a selected slave over a LANES-bit bus, MSB first.
// Optional feature macro: SYSX_BUSIRQ_EN (slave interrupt -> STATUS.BIRQ).
module sysx_master_v2
    import sysx_v2_pkg::*;
#(
    parameter int LANES   = 8,
    parameter int DEPTH   = 256,
    parameter int SELECTS = 3,
    parameter int DIV_W   = 12,
    parameter int SEL_W   = $clog2(SELECTS + 1)
) (
    input  logic             iClock,
    input  logic             iReset,
    sysx_master_v2_if.slave  cpu,
    output logic             oBusClock,
    output logic [SEL_W-1:0] oBusSelect,
    output logic [LANES-1:0] oBusMOSI,
    input  logic [LANES-1:0] iBusMISO,
    input  logic             iBusInterrupt
);
    localparam int         AW      = $clog2(DEPTH);
    localparam logic [5:0] BEATS_C = 6'(32 / LANES);

    state_t             state_q, state_d;
    logic               ie_q, ie_d, done_q, done_d, err_q, err_d, birq_q, birq_d;
    logic [SEL_W-1:0]   sel_q, sel_d, bsel_q, bsel_d;
    logic [15:0]        len_q, len_d, xlen_q, xlen_d, wcnt_q, wcnt_d;
    logic [DIV_W-1:0]   div_q, div_d, div_act_q, div_act_d, cnt_q, cnt_d;
    logic [AW-1:0]      mosi_ptr_q, mosi_ptr_d, miso_ptr_q, miso_ptr_d;
    logic [5:0]         bcnt_q, bcnt_d;
    logic [31:0]        tx_q, tx_d, rx_q, rx_d, rdat_q, rdat_d;
    logic               bclk_q, bclk_d, irq_q, irq_d, rd_miso_q, rd_miso_d;
    logic [LANES-1:0]   bmosi_q, bmosi_d;
    logic               go, tick, busy, birq_set, miso_we, mosi_wr;
    logic [15:0]        go_len;
    logic [AW-1:0]      eng_rd_addr;
    logic [31:0]        mosi_rd, miso_rd, mosi_b_unused, miso_a_unused;

    assign go      = cpu.iWrite && (cpu.iAddress == REG_CTRL) && cpu.iData[CTRL_GO];
    assign go_len  = cpu.iData[CTRL_LEN +: 16];
    assign busy    = (state_q != ST_IDLE);
    assign tick    = (state_q == ST_SHIFT) && (cnt_q == div_act_q);
    assign mosi_wr = cpu.iWrite && (cpu.iAddress == REG_MOSI_DATA);
    assign eng_rd_addr = wcnt_d[AW-1:0];

`ifdef SYSX_BUSIRQ_EN
    logic sync1_q, sync2_q, sync3_q;
    // Two-flop synchroniser plus one history flop for rising-edge detection.
    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= iBusInterrupt;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end
    assign birq_set = sync2_q && !sync3_q;
`else
    logic unused_bus_irq;
    assign unused_bus_irq = iBusInterrupt;
    assign birq_set       = 1'b0;
`endif

    // Register file, divider, transfer FSM next-state and CPU read mux.
    always_comb begin
        state_d = state_q;   ie_d = ie_q;       sel_d = sel_q;     len_d = len_q;
        div_d = div_q;       done_d = done_q;   err_d = err_q;     birq_d = birq_q;
        bsel_d = bsel_q;     xlen_d = xlen_q;   wcnt_d = wcnt_q;   bcnt_d = bcnt_q;
        tx_d = tx_q;         rx_d = rx_q;       bclk_d = bclk_q;   bmosi_d = bmosi_q;
        mosi_ptr_d = mosi_ptr_q;  miso_ptr_d = miso_ptr_q;  rdat_d = rdat_q;
        miso_we = 1'b0;

        if (cpu.iWrite) begin
            case (cpu.iAddress)
                REG_CTRL: begin
                    ie_d  = cpu.iData[CTRL_IE];
                    sel_d = cpu.iData[CTRL_SEL +: SEL_W];
                    len_d = go_len;
                end
                REG_CLKDIV:    div_d = cpu.iData[DIV_W-1:0];
                REG_STATUS: begin
                    done_d = done_q & ~cpu.iData[STAT_DONE];
                    err_d  = err_q  & ~cpu.iData[STAT_ERR];
                    birq_d = birq_q & ~cpu.iData[STAT_BIRQ];
                end
                REG_MOSI_PTR:  mosi_ptr_d = cpu.iData[AW-1:0];
                REG_MOSI_DATA: mosi_ptr_d = mosi_ptr_q + 1'b1;
                REG_MISO_PTR:  miso_ptr_d = cpu.iData[AW-1:0];
                default: ;
            endcase
        end
        if (cpu.iRead && (cpu.iAddress == REG_MISO_DATA)) miso_ptr_d = miso_ptr_q + 1'b1;

        // The divider only runs while shifting; a new CLKDIV is adopted when idle or at a wrap.
        cnt_d     = (state_q != ST_SHIFT || tick) ? '0 : cnt_q + 1'b1;
        div_act_d = (!busy || tick) ? div_q : div_act_q;

        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    if (go_len != 16'd0) begin
                        xlen_d  = go_len;
                        bsel_d  = cpu.iData[CTRL_SEL +: SEL_W];
                        wcnt_d  = '0;
                        state_d = ST_LOAD;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                // First beat is presented now so it is stable before the first rising edge.
                bmosi_d = mosi_rd[31 -: LANES];
                tx_d    = mosi_rd << LANES;
                bcnt_d  = '0;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (tick) begin
                    if (!bclk_q) begin
                        bclk_d = 1'b1;
                        rx_d   = {rx_q[31-LANES:0], iBusMISO};
                        bcnt_d = bcnt_q + 1'b1;
                    end else begin
                        bclk_d = 1'b0;
                        if (bcnt_q == BEATS_C) begin
                            state_d = ST_STORE;
                        end else begin
                            bmosi_d = tx_q[31 -: LANES];
                            tx_d    = tx_q << LANES;
                        end
                    end
                end
            end
            ST_STORE: begin
                miso_we = 1'b1;
                wcnt_d  = wcnt_q + 16'd1;
                if (wcnt_d == xlen_q) begin
                    bsel_d  = '0;
                    bmosi_d = '0;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                bclk_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (go && busy) err_d  = 1'b1;
        if (birq_set)   birq_d = 1'b1;
        irq_d = (ie_d & done_d) | birq_d;

        rd_miso_d = cpu.iRead && (cpu.iAddress == REG_MISO_DATA);
        if (cpu.iRead) begin
            rdat_d = '0;
            case (cpu.iAddress)
                REG_CTRL: begin
                    rdat_d[CTRL_IE]            = ie_q;
                    rdat_d[CTRL_SEL +: SEL_W]  = sel_q;
                    rdat_d[CTRL_LEN +: 16]     = len_q;
                end
                REG_CLKDIV:   rdat_d = 32'(div_q);
                REG_STATUS:   rdat_d = {28'd0, birq_q, err_q, done_q, busy};
                REG_MOSI_PTR: rdat_d = 32'(mosi_ptr_q);
                REG_MISO_PTR: rdat_d = 32'(miso_ptr_q);
                REG_BAD:      rdat_d = BADC0DE;
                default:      rdat_d = '0;
            endcase
        end
    end

    // State and register update; reset clears every control and bus output immediately.
    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            state_q <= ST_IDLE;  ie_q <= 1'b0;   sel_q <= '0;     len_q <= '0;
            div_q <= '0;         done_q <= 1'b0; err_q <= 1'b0;   birq_q <= 1'b0;
            bsel_q <= '0;        xlen_q <= '0;   wcnt_q <= '0;    bcnt_q <= '0;
            tx_q <= '0;          rx_q <= '0;     bclk_q <= 1'b0;  bmosi_q <= '0;
            mosi_ptr_q <= '0;    miso_ptr_q <= '0;  rdat_q <= '0; rd_miso_q <= 1'b0;
            div_act_q <= '0;     cnt_q <= '0;    irq_q <= 1'b0;
        end else begin
            state_q <= state_d;  ie_q <= ie_d;   sel_q <= sel_d;  len_q <= len_d;
            div_q <= div_d;      done_q <= done_d; err_q <= err_d; birq_q <= birq_d;
            bsel_q <= bsel_d;    xlen_q <= xlen_d; wcnt_q <= wcnt_d; bcnt_q <= bcnt_d;
            tx_q <= tx_d;        rx_q <= rx_d;   bclk_q <= bclk_d; bmosi_q <= bmosi_d;
            mosi_ptr_q <= mosi_ptr_d; miso_ptr_q <= miso_ptr_d; rdat_q <= rdat_d; rd_miso_q <= rd_miso_d;
            div_act_q <= div_act_d; cnt_q <= cnt_d; irq_q <= irq_d;
        end
    end

    sysx_v2_buffer #(.DEPTH(DEPTH)) u_mosi_buf (
        .clk_i(iClock),
        .a_we_i(1'b0), .a_addr_i(eng_rd_addr), .a_wdata_i(32'd0), .a_rdata_o(mosi_rd),
        .b_we_i(mosi_wr), .b_addr_i(mosi_ptr_q), .b_wdata_i(cpu.iData), .b_rdata_o(mosi_b_unused)
    );

    sysx_v2_buffer #(.DEPTH(DEPTH)) u_miso_buf (
        .clk_i(iClock),
        .a_we_i(miso_we), .a_addr_i(wcnt_q[AW-1:0]), .a_wdata_i(rx_q), .a_rdata_o(miso_a_unused),
        .b_we_i(1'b0), .b_addr_i(miso_ptr_q), .b_wdata_i(32'd0), .b_rdata_o(miso_rd)
    );

    assign cpu.oData      = rd_miso_q ? miso_rd : rdat_q;
    assign cpu.oInterrupt = irq_q;
    assign oBusClock      = bclk_q;
    assign oBusSelect     = bsel_q;
    assign oBusMOSI       = bmosi_q;
endmodule

// File: tb/tb_sysx_master_v2.sv
// Directed testbench for sysx_master_v2 (LANES=8, DEPTH=256) with MISO looped back to MOSI.
module tb_sysx_master_v2;
    logic       iClock = 1'b0;
    logic       iReset = 1'b0;
    logic       oBusClock;
    logic [1:0] oBusSelect;
    logic [7:0] oBusMOSI;
    logic [7:0] iBusMISO;
    logic       iBusInterrupt = 1'b0;

    int checks = 0;
    int errors = 0;

    sysx_master_v2_if cpu ();

    sysx_master_v2 #(.LANES(8), .DEPTH(256), .SELECTS(3), .DIV_W(12)) dut (
        .iClock(iClock), .iReset(iReset), .cpu(cpu),
        .oBusClock(oBusClock), .oBusSelect(oBusSelect), .oBusMOSI(oBusMOSI),
        .iBusMISO(iBusMISO), .iBusInterrupt(iBusInterrupt)
    );

    assign iBusMISO = oBusMOSI;
    always #5 iClock = ~iClock;

    // Bus monitor: logs rising/falling bus-clock edges, beats and select mismatches.
    int         cyc = 0, rise_cnt = 0, fall_cnt = 0, sel_bad = 0;
    logic       prev_bclk = 1'b0;
    logic [1:0] exp_sel = 2'd0;
    logic [7:0] beats [256];
    int         rise_cyc [256];
    int         fall_cyc [256];

    always @(negedge iClock) begin
        cyc       <= cyc + 1;
        prev_bclk <= oBusClock;
        if (oBusClock && !prev_bclk) begin
            beats[rise_cnt[7:0]]    <= oBusMOSI;
            rise_cyc[rise_cnt[7:0]] <= cyc;
            rise_cnt                <= rise_cnt + 1;
            if (oBusSelect !== exp_sel) sel_bad <= sel_bad + 1;
        end
        if (!oBusClock && prev_bclk) begin
            fall_cyc[fall_cnt[7:0]] <= cyc;
            fall_cnt                <= fall_cnt + 1;
        end
    end

    task automatic cpu_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge iClock);
        cpu.iAddress = a; cpu.iData = d; cpu.iWrite = 1'b1;
        @(negedge iClock);
        cpu.iWrite = 1'b0;
    endtask

    task automatic cpu_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge iClock);
        cpu.iAddress = a; cpu.iRead = 1'b1;
        @(negedge iClock);
        cpu.iRead = 1'b0;
        d = cpu.oData;
    endtask

    task automatic wait_idle(input string name);
        logic [31:0] st;
        bit ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            cpu_read(3'd2, st);
            if (st[0] === 1'b0) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: transfer still busy after budget, status=%h required busy=0", name, st);
        end
    endtask

    task automatic test_reset();
        logic [31:0] r;
        checks++; if (cpu.oData !== 32'd0) begin errors++; $display("FAIL rst_odata: got %h want 0", cpu.oData); end
        checks++; if (cpu.oInterrupt !== 1'b0) begin errors++; $display("FAIL rst_irq: got %b want 0", cpu.oInterrupt); end
        checks++; if (oBusClock !== 1'b0) begin errors++; $display("FAIL rst_bclk: got %b want 0", oBusClock); end
        checks++; if (oBusSelect !== 2'd0) begin errors++; $display("FAIL rst_sel: got %0d want 0", oBusSelect); end
        checks++; if (oBusMOSI !== 8'd0) begin errors++; $display("FAIL rst_mosi: got %h want 0", oBusMOSI); end
        cpu_read(3'd2, r);
        checks++; if (r !== 32'd0) begin errors++; $display("FAIL rst_status: got %h want 0", r); end
        cpu_read(3'd0, r);
        checks++; if (r !== 32'd0) begin errors++; $display("FAIL rst_ctrl: got %h want 0", r); end
        cpu_read(3'd7, r);
        checks++; if (r !== 32'h0BADC0DE) begin errors++; $display("FAIL reg7: got %h want 0badc0de", r); end
    endtask

    task automatic test_single_word();
        logic [31:0] r;
        int rb, sb;
        cpu_write(3'd1, 32'd0);
        cpu_write(3'd3, 32'd0);
        cpu_write(3'd4, 32'hA1B2C3D4);
        rb = rise_cnt; sb = sel_bad; exp_sel = 2'd2;
        cpu_write(3'd0, 32'h0001_0009);
        wait_idle("single_wait");
        checks++; if (rise_cnt - rb != 4) begin errors++; $display("FAIL single_edges: got %0d want 4", rise_cnt - rb); end
        checks++;
        if ({beats[rb], beats[rb+1], beats[rb+2], beats[rb+3]} !== 32'hA1B2C3D4) begin
            errors++; $display("FAIL single_beats: got %h %h %h %h want a1 b2 c3 d4", beats[rb], beats[rb+1], beats[rb+2], beats[rb+3]);
        end
        checks++; if (sel_bad != sb) begin errors++; $display("FAIL single_sel: %0d edges with wrong select, want 0", sel_bad - sb); end
        cpu_read(3'd2, r);
        checks++; if (r !== 32'h2) begin errors++; $display("FAIL single_status: got %h want 2", r); end
        checks++; if (oBusSelect !== 2'd0) begin errors++; $display("FAIL single_sel_end: got %0d want 0", oBusSelect); end
        cpu_write(3'd5, 32'd0);
        cpu_read(3'd6, r);
        checks++; if (r !== 32'hA1B2C3D4) begin errors++; $display("FAIL single_miso: got %h want a1b2c3d4", r); end
        cpu_read(3'd5, r);
        checks++; if (r !== 32'd1) begin errors++; $display("FAIL single_misoptr: got %h want 1", r); end
    endtask

    task automatic test_multi_word_div();
        logic [31:0] r;
        logic [31:0] w [3];
        int rb, fb;
        w[0] = 32'h01234567; w[1] = 32'h89ABCDEF; w[2] = 32'hDEADBEEF;
        cpu_write(3'd2, 32'h2);
        cpu_write(3'd3, 32'd0);
        for (int i = 0; i < 3; i++) cpu_write(3'd4, w[i]);
        cpu_write(3'd1, 32'd3);
        rb = rise_cnt; fb = fall_cnt; exp_sel = 2'd1;
        cpu_write(3'd0, 32'h0003_0007);
        wait_idle("multi_wait");
        checks++; if (rise_cnt - rb != 12) begin errors++; $display("FAIL multi_edges: got %0d want 12", rise_cnt - rb); end
        checks++; if (fall_cyc[fb] - rise_cyc[rb] != 4) begin errors++; $display("FAIL multi_halfper: got %0d want 4", fall_cyc[fb] - rise_cyc[rb]); end
        checks++; if (cpu.oInterrupt !== 1'b1) begin errors++; $display("FAIL multi_irq_on: got %b want 1", cpu.oInterrupt); end
        cpu_write(3'd5, 32'd0);
        for (int i = 0; i < 3; i++) begin
            cpu_read(3'd6, r);
            checks++; if (r !== w[i]) begin errors++; $display("FAIL multi_miso%0d: got %h want %h", i, r, w[i]); end
        end
        cpu_write(3'd2, 32'h2);
        checks++; if (cpu.oInterrupt !== 1'b0) begin errors++; $display("FAIL multi_irq_off: got %b want 0", cpu.oInterrupt); end
    endtask

    task automatic test_go_while_busy();
        logic [31:0] r;
        int rb, sb;
        cpu_write(3'd1, 32'd1);
        rb = rise_cnt; sb = sel_bad; exp_sel = 2'd3;
        cpu_write(3'd0, 32'h0002_000D);
        cpu_write(3'd0, 32'h0001_0005);
        wait_idle("busy_wait");
        checks++; if (rise_cnt - rb != 8) begin errors++; $display("FAIL busy_edges: got %0d want 8", rise_cnt - rb); end
        checks++; if (sel_bad != sb) begin errors++; $display("FAIL busy_sel: %0d edges with wrong select, want 0", sel_bad - sb); end
        cpu_read(3'd2, r);
        checks++; if (r !== 32'h6) begin errors++; $display("FAIL busy_status: got %h want 6", r); end
        cpu_write(3'd2, 32'h6);
        rb = rise_cnt;
        cpu_write(3'd0, 32'h0000_0001);
        cpu_read(3'd2, r);
        checks++; if (r !== 32'h2) begin errors++; $display("FAIL len0_status: got %h want 2", r); end
        repeat (10) @(negedge iClock);
        checks++; if (rise_cnt != rb) begin errors++; $display("FAIL len0_edges: got %0d want 0", rise_cnt - rb); end
        cpu_write(3'd2, 32'h2);
    endtask

    task automatic test_ptr_wrap();
        logic [31:0] r;
        cpu_write(3'd3, 32'd255);
        cpu_write(3'd4, 32'h11111111);
        cpu_write(3'd4, 32'h22222222);
        cpu_read(3'd3, r);
        checks++; if (r !== 32'd1) begin errors++; $display("FAIL wrap_ptr: got %h want 1", r); end
        cpu_write(3'd1, 32'd0);
        exp_sel = 2'd1;
        cpu_write(3'd0, 32'h0001_0005);
        wait_idle("wrap_wait");
        cpu_write(3'd5, 32'd0);
        cpu_read(3'd6, r);
        checks++; if (r !== 32'h22222222) begin errors++; $display("FAIL wrap_word0: got %h want 22222222", r); end
        cpu_write(3'd2, 32'h2);
    endtask

    task automatic test_reset_mid();
        logic [31:0] r;
        bit seen = 1'b0;
        cpu_write(3'd1, 32'd3);
        exp_sel = 2'd1;
        cpu_write(3'd0, 32'h0001_0005);
        for (int i = 0; i < 100; i++) begin
            @(negedge iClock);
            if (oBusClock === 1'b1) begin seen = 1'b1; break; end
        end
        checks++; if (!seen) begin errors++; $display("FAIL mid_shift: bus clock never rose, want high within 100 cycles"); end
        #2 iReset = 1'b0;
        #1;
        checks++; if (oBusSelect !== 2'd0) begin errors++; $display("FAIL mid_sel: got %0d want 0", oBusSelect); end
        checks++; if (oBusClock !== 1'b0) begin errors++; $display("FAIL mid_bclk: got %b want 0", oBusClock); end
        checks++; if (oBusMOSI !== 8'd0) begin errors++; $display("FAIL mid_mosi: got %h want 0", oBusMOSI); end
        repeat (2) @(negedge iClock);
        iReset = 1'b1;
        cpu_read(3'd2, r);
        checks++; if (r !== 32'd0) begin errors++; $display("FAIL mid_status: got %h want 0", r); end
    endtask

    task automatic test_bus_irq();
        logic [31:0] r;
        bit seen = 1'b0;
        @(negedge iClock);
        iBusInterrupt = 1'b1;
        repeat (2) @(negedge iClock);
        iBusInterrupt = 1'b0;
`ifdef SYSX_BUSIRQ_EN
        for (int i = 0; i < 3; i++) begin
            if (cpu.oInterrupt === 1'b1) begin seen = 1'b1; break; end
            @(negedge iClock);
        end
        checks++; if (!seen) begin errors++; $display("FAIL birq_irq: oInterrupt=%b want 1 within 3 cycles", cpu.oInterrupt); end
        cpu_read(3'd2, r);
        checks++; if (r !== 32'h8) begin errors++; $display("FAIL birq_status: got %h want 8", r); end
        cpu_write(3'd2, 32'h8);
        checks++; if (cpu.oInterrupt !== 1'b0) begin errors++; $display("FAIL birq_clear: got %b want 0", cpu.oInterrupt); end
`else
        for (int i = 0; i < 6; i++) begin
            if (cpu.oInterrupt !== 1'b0) seen = 1'b1;
            @(negedge iClock);
        end
        checks++; if (seen) begin errors++; $display("FAIL birq_ignored: oInterrupt rose, want 0"); end
        cpu_read(3'd2, r);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL birq_status: got %h want 0", r); end
`endif
    endtask

    initial begin
        cpu.iAddress = 3'd0; cpu.iData = 32'd0; cpu.iWrite = 1'b0; cpu.iRead = 1'b0;
        repeat (3) @(negedge iClock);
        iReset = 1'b1;
        @(negedge iClock);
        test_reset();
        test_single_word();
        test_multi_word_div();
        test_go_while_busy();
        test_ptr_wrap();
        test_reset_mid();
        test_bus_irq();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end
endmodule
